debug_console: RTL and testbench
================================

# debug_console

Memory-mapped debug console peripheral that responds to the CPU store/load channel and serializes console bytes onto a UART TX line. Firmware writes characters to a data register. The block buffers them in a FIFO and transmits them 8N1, LSB first, with `cts_i` flow control. A one-cycle `char_valid_o` strobe mirrors every transmitted byte, so simulation benches can collect console output without decoding the UART line.

## Interface
- `FIFO_DEPTH`, 16: character FIFO entries; power of two, ≥ 2.
- `BAUD_DIVIDER`, 868: clock cycles per UART bit; ≥ 4.

- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset; synchronous, active-low.
- `write_request_i` in 1: one-cycle write request.
- `write_address_i` in 2: word offset (0 DATA, 1 STATUS, 2 CONTROL).
- `write_data_i` in 32: write data.
- `write_done_o` out 1: write accepted.
- `write_error_o` out 1: write rejected.
- `read_request_i` in 1: one-cycle read request.
- `read_address_i` in 2: word offset.
- `read_data_o` out 32: read data; valid while `read_done_o` is high, 0 otherwise.
- `read_done_o` out 1: read complete.
- `read_error_o` out 1: read rejected.
- `cts_i` in 1: clear-to-send, active-high.
- `tx_o` out 1: UART transmit line, idle high.
- `char_valid_o` out 1: one-cycle strobe when a byte is popped for transmission.
- `char_o` out 8: byte popped; valid with `char_valid_o`.

## Operation
- Register map
  - DATA (0): write only. `write_data_i[7:0]` is pushed into the FIFO. Reads return error.
  - STATUS (1): read only. bit0 full, bit1 empty, bit2 tx busy (FSM not IDLE), bits[15:8] FIFO count, other bits 0. Writes return error.
  - CONTROL (2): read/write. bit0 enable (reset 1). bit1 flush: write-1 self-clearing, reads as 0. Other bits ignored on write, read as 0.
  - Offset 3: error on both read and write.
- Write handshake
  - Request is sampled at edge E. Exactly one of `write_done_o`/`write_error_o` is high for the single cycle after E.
  - A DATA write while full (count == `FIFO_DEPTH`, sampled before this edge) returns error and drops the byte, even if a pop occurs on the same edge.
- Read handshake: same timing. `read_data_o` is registered and returns to 0 the following cycle. Simultaneous read and write requests are both serviced independently.
- FIFO
  - Count range is 0..`FIFO_DEPTH`. Pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop on the same edge leaves the count unchanged.
  - Flush sets count to 0 and both pointers to 0. A frame already in progress completes.
  - A flush and a DATA write in the same cycle cannot occur, because both use the single write port.
- TX state machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: when enable = 1, the FIFO is non-empty and `cts_i` = 1, pop the head, latch the shift register, pulse `char_valid_o`/`char_o`, and go to START. `cts_i` is examined only in IDLE.
  - START: `tx_o` = 0 for `BAUD_DIVIDER` cycles.
  - DATA: 8 bits, LSB first, each `BAUD_DIVIDER` cycles, using a 3-bit bit counter.
  - STOP: `tx_o` = 1 for `BAUD_DIVIDER` cycles, then IDLE.
  - The baud counter runs 0..`BAUD_DIVIDER`−1 and is reset on every state change.
  - Clearing enable mid-frame does not abort the frame; it only blocks the next pop.
- Reset values: `tx_o` = 1; all other outputs 0; FIFO empty; state IDLE; enable = 1. Reset mid-frame returns `tx_o` high on the next edge and discards the FIFO.

## Timing
- Register access latency: 1 cycle from request to done/error.
- DATA write at edge E0 into an empty FIFO with the FSM idle:
  - count becomes 1 after E0;
  - IDLE pops at edge E1 (`char_valid_o` high in the cycle after E1, count back to 0);
  - `tx_o` falls after E1.
- Frame length: exactly 10 × `BAUD_DIVIDER` cycles.
- Back-to-back frames: the next pop occurs on the edge the FSM enters IDLE + 1. Inter-frame idle gap is 1 cycle of `tx_o` = 1 beyond the stop bit.
- STATUS reflects the register values before the sampling edge.

## Test plan
- Basic transmit: `BAUD_DIVIDER` = 4. Write DATA 0x41 → `write_done_o` 1 cycle later; `char_valid_o` with `char_o` = 0x41 one cycle after; `tx_o` sequence 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles, then high.
- Full FIFO: enable = 0. Write 16 bytes → 16 dones. 17th write → `write_error_o`. STATUS read = 0x0000_1001.
- Flow control: `cts_i` = 0 with 3 bytes queued → `tx_o` stays 1 and STATUS busy = 0. Raise `cts_i` → 3 consecutive frames, each with 1 idle cycle between. Drop `cts_i` mid-frame → the current frame completes.
- Flush: enable = 0. Queue 5 bytes. Write CONTROL = 0x3 → STATUS count 0, empty = 1. CONTROL reads 0x1.
- Errors and wrap-around: read DATA → `read_error_o`; write STATUS → `write_error_o`; access offset 3 → error. Push and pop 40 bytes (0x00..0x27) → `char_o` order is preserved across pointer wrap.
- Reset mid-frame: assert `rst_n_i` = 0 during DATA state → after the edge `tx_o` = 1, FIFO empty, no `char_valid_o` until a new write.

Source files
------------

// File: rtl/debug_console.sv
// debug_console: memory-mapped console peripheral. CPU stores to DATA are
// queued in a character FIFO and shifted out 8N1, LSB first, on tx_o under
// cts_i flow control. Each popped byte is also mirrored on char_valid_o/char_o.
module debug_console #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIVIDER = 868
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        write_request_i,
  input  logic [1:0]  write_address_i,
  input  logic [31:0] write_data_i,
  output logic        write_done_o,
  output logic        write_error_o,
  input  logic        read_request_i,
  input  logic [1:0]  read_address_i,
  output logic [31:0] read_data_o,
  output logic        read_done_o,
  output logic        read_error_o,
  input  logic        cts_i,
  output logic        tx_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIVIDER);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Character storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             enable;

  // Transmitter
  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_data;
  logic        wr_control;
  logic        push;
  logic        pop;
  logic        flush;
  logic        baud_done;
  logic [31:0] status_word;

  // Bits above the character byte carry no meaning for any register.
  logic unused_wdata;
  assign unused_wdata = ^write_data_i[31:8];

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign wr_data    = write_request_i && (write_address_i == ADDR_DATA);
  assign wr_control = write_request_i && (write_address_i == ADDR_CONTROL);
  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a write.
  assign push       = wr_data && !fifo_full;
  assign flush      = wr_control && write_data_i[1];
  assign baud_done  = (baud_cnt == BAUD_W'(BAUD_DIVIDER - 1));

  // STATUS snapshot of the current (pre-edge) register values
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    status_word       = '0;
    status_word[0]    = fifo_full;
    status_word[1]    = fifo_empty;
    status_word[2]    = (state_q != ST_IDLE);
    status_word[15:8] = 8'(count);
  end

  // Write channel: one-cycle done/error response and the CONTROL enable bit
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      write_done_o  <= 1'b0;
      write_error_o <= 1'b0;
      enable        <= 1'b1;
    end else begin
      write_done_o  <= push || wr_control;
      write_error_o <= write_request_i && !(push || wr_control);
      if (wr_control) begin
        enable <= write_data_i[0];
      end
    end
  end

  // Read channel: registered data that falls back to zero the following cycle
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      read_done_o  <= 1'b0;
      read_error_o <= 1'b0;
      read_data_o  <= '0;
    end else begin
      read_done_o  <= 1'b0;
      read_error_o <= 1'b0;
      read_data_o  <= '0;
      if (read_request_i) begin
        case (read_address_i)
          ADDR_STATUS: begin
            read_done_o <= 1'b1;
            read_data_o <= status_word;
          end
          ADDR_CONTROL: begin
            read_done_o <= 1'b1;
            read_data_o <= {31'b0, enable};
          end
          default: read_error_o <= 1'b1;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; flush overrides any simultaneous pop
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are valid.
    if (push) begin
      fifo_mem[wr_ptr] <= write_data_i[7:0];
    end
  end

  // TX state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // TX next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop)                            state_d = ST_START;
      ST_START: if (baud_done)                      state_d = ST_DATA;
      ST_DATA:  if (baud_done && bit_cnt == 3'd7)   state_d = ST_STOP;
      ST_STOP:  if (baud_done)                      state_d = ST_IDLE;
      default:                                      state_d = ST_IDLE;
    endcase
  end

  // TX outputs: line level and the pop decision taken only while idle
  always_comb begin
    pop  = 1'b0;
    tx_o = 1'b1;
    case (state_q)
      ST_IDLE:  pop  = enable && !fifo_empty && cts_i;
      ST_START: tx_o = 1'b0;
      ST_DATA:  tx_o = shift_q[0];
      default:  tx_o = 1'b1;
    endcase
  end

  // TX datapath: baud/bit counters, shift register and the mirror strobe
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      char_valid_o <= 1'b0;
      char_o       <= '0;
    end else begin
      char_valid_o <= pop;
      if (pop) begin
        shift_q <= fifo_mem[rd_ptr];
        char_o  <= fifo_mem[rd_ptr];
      end else if (state_q == ST_DATA && baud_done) begin
        shift_q <= shift_q >> 1;
      end

      // Restart the bit period on every state change and at each bit boundary.
      if (state_q == ST_IDLE || state_d != state_q || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end

      if (state_q != ST_DATA) begin
        bit_cnt <= '0;
      end else if (baud_done) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_debug_console.sv
// Self-checking bench for debug_console: register-access vector tables,
// hand-written multi-cycle sequences, and a randomized run checked cycle by
// cycle against a transaction-level model (byte queue plus frame timeline).
module tb_debug_console;

  localparam int DEPTH = 16;
  localparam int BD    = 4;
  localparam int FRAME = 10 * BD;

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_CONTROL = 2'd2;
  localparam logic [1:0] A_BAD     = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        write_request_i;
  logic [1:0]  write_address_i;
  logic [31:0] write_data_i;
  logic        write_done_o;
  logic        write_error_o;
  logic        read_request_i;
  logic [1:0]  read_address_i;
  logic [31:0] read_data_o;
  logic        read_done_o;
  logic        read_error_o;
  logic        cts_i;
  logic        tx_o;
  logic        char_valid_o;
  logic [7:0]  char_o;

  debug_console #(.FIFO_DEPTH(DEPTH), .BAUD_DIVIDER(BD)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .write_request_i (write_request_i),
    .write_address_i (write_address_i),
    .write_data_i    (write_data_i),
    .write_done_o    (write_done_o),
    .write_error_o   (write_error_o),
    .read_request_i  (read_request_i),
    .read_address_i  (read_address_i),
    .read_data_o     (read_data_o),
    .read_done_o     (read_done_o),
    .read_error_o    (read_error_o),
    .cts_i           (cts_i),
    .tx_o            (tx_o),
    .char_valid_o    (char_valid_o),
    .char_o          (char_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t tbl[$];

  logic [9:0] basic_pat = 10'b1010000010;  // index 0 is the start bit
  logic [7:0] fc_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit busy);
    logic [31:0] s = '0;
    s[0]    = (cnt == DEPTH);
    s[1]    = (cnt == 0);
    s[2]    = busy;
    s[15:8] = 8'(cnt);
    return s;
  endfunction

  // Expected UART level at a given cycle offset from the pop edge.
  function automatic logic uart_level(input int off, input logic [7:0] b);
    int idx;
    if (off < 0 || off >= FRAME) return 1'b1;
    idx = off / BD;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic void add(input bit w, input logic [1:0] a, input logic [31:0] d,
                              input logic ed, input logic ee, input logic [31:0] er,
                              input string nm);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d;
    v.exp_done = ed; v.exp_err = ee; v.exp_rdata = er; v.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    rst_n_i         = 1'b0;
    write_request_i = 1'b0;
    write_address_i = '0;
    write_data_i    = '0;
    read_request_i  = 1'b0;
    read_address_i  = '0;
    cts_i           = 1'b1;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic access(input bit is_wr, input logic [1:0] addr, input logic [31:0] data,
                        output logic done, output logic err, output logic [31:0] rdata);
    if (is_wr) begin
      write_request_i = 1'b1; write_address_i = addr; write_data_i = data;
    end else begin
      read_request_i = 1'b1; read_address_i = addr;
    end
    tick();
    write_request_i = 1'b0;
    read_request_i  = 1'b0;
    done  = is_wr ? write_done_o  : read_done_o;
    err   = is_wr ? write_error_o : read_error_o;
    rdata = read_data_o;
  endtask

  task automatic run_table();
    logic d, e;
    logic [31:0] r;
    foreach (tbl[i]) begin
      access(tbl[i].is_wr, tbl[i].addr, tbl[i].data, d, e, r);
      check({tbl[i].name, " done"},  d, tbl[i].exp_done);
      check({tbl[i].name, " error"}, e, tbl[i].exp_err);
      check({tbl[i].name, " rdata"}, r, tbl[i].exp_rdata);
    end
    tbl.delete();
  endtask

  // Cycle-accurate checking against a queue of pending bytes and a frame
  // timeline: a byte pushed at edge n pops no earlier than n+1, and never
  // before the previous pop + one frame + one idle cycle.
  task automatic run_model(input int ncycles, input bit seq_mode);
    logic [7:0] pend[$];
    int         cyc       = 0;
    int         next_free = 0;
    int         last_pop  = -100000;
    logic [7:0] last_byte = '0;
    int         seq       = 0;
    int         seen      = 0;
    bit         wr, rd, busy_before, pop_e, push_e;
    int         cnt_before;
    logic [7:0] wb, pb;
    string      tag;
    tag = seq_mode ? "wrap" : "rand";
    do_reset();
    for (int t = 0; t < ncycles; t++) begin
      if (seq_mode) begin
        wr = (seq < 40) && (pend.size() < DEPTH);
        wb = 8'(seq);
      end else begin
        if (t < 200)       wr = ($urandom_range(1, 0) == 1);
        else if (t < 1200) wr = ($urandom_range(39, 0) == 0);
        else               wr = 1'b0;
        wb = 8'($urandom);
      end
      rd = ($urandom_range(3, 0) == 0);
      write_request_i = wr;
      write_address_i = A_DATA;
      write_data_i    = {24'($urandom), wb};
      read_request_i  = rd;
      read_address_i  = A_STATUS;
      tick();
      cyc++;
      write_request_i = 1'b0;
      read_request_i  = 1'b0;

      cnt_before  = pend.size();
      busy_before = ((cyc - 1 - last_pop) >= 0) && ((cyc - 1 - last_pop) < FRAME);
      pop_e       = (cnt_before > 0) && (cyc >= next_free);
      push_e      = wr && (cnt_before < DEPTH);
      pb          = '0;
      if (pop_e) begin
        pb        = pend.pop_front();
        last_pop  = cyc;
        last_byte = pb;
        next_free = cyc + FRAME + 1;
      end
      if (push_e) begin
        pend.push_back(wb);
        if (seq_mode) seq++;
      end

      check({tag, " write_done"},  write_done_o,  push_e);
      check({tag, " write_error"}, write_error_o, wr && !push_e);
      check({tag, " read_done"},   read_done_o,   rd);
      check({tag, " read_data"},   read_data_o,   rd ? status_word(cnt_before, busy_before) : 32'h0);
      check({tag, " char_valid"},  char_valid_o,  pop_e);
      if (pop_e) check({tag, " char_o"}, char_o, pb);
      check({tag, " tx"}, tx_o, uart_level(cyc - last_pop, last_byte));
      if (char_valid_o) seen++;
    end
    if (seq_mode) check("wrap strobes seen", seen, 40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d, e;
    logic [31:0] r;
    int p;

    // ---------------- reset values ----------------
    do_reset();
    check("reset tx_o", tx_o, 1'b1);
    check("reset write_done", write_done_o, 1'b0);
    check("reset write_error", write_error_o, 1'b0);
    check("reset read_done", read_done_o, 1'b0);
    check("reset read_error", read_error_o, 1'b0);
    check("reset read_data", read_data_o, 32'h0);
    check("reset char_valid", char_valid_o, 1'b0);
    check("reset char_o", char_o, 8'h00);

    // ---------------- register map and errors ----------------
    add(0, A_DATA,    32'h0,         0, 1, 32'h0, "rd DATA");
    add(1, A_STATUS,  32'hFFFF_FFFF, 0, 1, 32'h0, "wr STATUS");
    add(0, A_BAD,     32'h0,         0, 1, 32'h0, "rd off3");
    add(1, A_BAD,     32'h41,        0, 1, 32'h0, "wr off3");
    add(0, A_STATUS,  32'h0,         1, 0, 32'h2, "rd STATUS idle");
    add(0, A_CONTROL, 32'h0,         1, 0, 32'h1, "rd CONTROL reset");
    add(1, A_CONTROL, 32'h0,         1, 0, 32'h0, "wr CONTROL 0");
    add(0, A_CONTROL, 32'h0,         1, 0, 32'h0, "rd CONTROL off");
    add(1, A_CONTROL, 32'hFFFF_FFFD, 1, 0, 32'h0, "wr CONTROL junk");
    add(0, A_CONTROL, 32'h0,         1, 0, 32'h1, "rd CONTROL junk");
    add(1, A_CONTROL, 32'h2,         1, 0, 32'h0, "wr CONTROL flush");
    add(0, A_CONTROL, 32'h0,         1, 0, 32'h0, "rd CONTROL flush");
    add(1, A_CONTROL, 32'h1,         1, 0, 32'h0, "wr CONTROL en");
    add(0, A_CONTROL, 32'h0,         1, 0, 32'h1, "rd CONTROL en");
    run_table();
    tick();
    check("read_data returns to 0", read_data_o, 32'h0);
    check("read_done single cycle", read_done_o, 1'b0);

    // Simultaneous read and write are serviced independently.
    write_request_i = 1'b1; write_address_i = A_CONTROL; write_data_i = 32'h1;
    read_request_i  = 1'b1; read_address_i  = A_STATUS;
    tick();
    write_request_i = 1'b0; read_request_i = 1'b0;
    check("simul write_done", write_done_o, 1'b1);
    check("simul read_done", read_done_o, 1'b1);
    check("simul read_data", read_data_o, 32'h2);

    // ---------------- basic transmit ----------------
    do_reset();
    access(1, A_DATA, 32'h0000_0041, d, e, r);
    check("basic write_done", d, 1'b1);
    check("basic write_error", e, 1'b0);
    check("basic no early strobe", char_valid_o, 1'b0);
    tick();
    check("basic char_valid", char_valid_o, 1'b1);
    check("basic char_o", char_o, 8'h41);
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("basic tx[%0d]", i), tx_o, basic_pat[i/BD]);
      if (i > 0) check($sformatf("basic strobe off[%0d]", i), char_valid_o, 1'b0);
      tick();
    end
    check("basic tx idle after frame", tx_o, 1'b1);
    check("basic no second strobe", char_valid_o, 1'b0);

    // ---------------- full FIFO and pop-on-same-edge ----------------
    do_reset();
    add(1, A_CONTROL, 32'h0, 1, 0, 32'h0, "full disable");
    for (int i = 0; i < DEPTH; i++) add(1, A_DATA, 32'(i + 8'h60), 1, 0, 32'h0, $sformatf("full push%0d", i));
    add(1, A_DATA,    32'hEE, 0, 1, 32'h0,       "full 17th");
    add(0, A_STATUS,  32'h0,  1, 0, 32'h0000_1001, "full STATUS");
    add(1, A_CONTROL, 32'h1,  1, 0, 32'h0,       "full enable");
    add(1, A_DATA,    32'h77, 0, 1, 32'h0,       "full write during pop");
    add(0, A_STATUS,  32'h0,  1, 0, 32'h0000_0F04, "full STATUS after pop");
    add(1, A_CONTROL, 32'h3,  1, 0, 32'h0,       "full flush");
    add(0, A_STATUS,  32'h0,  1, 0, 32'h0000_0006, "full STATUS flushed busy");
    add(0, A_CONTROL, 32'h0,  1, 0, 32'h1,       "full CONTROL after flush");
    run_table();

    // ---------------- flush with 5 queued ----------------
    do_reset();
    add(1, A_CONTROL, 32'h0, 1, 0, 32'h0, "flush disable");
    for (int i = 0; i < 5; i++) add(1, A_DATA, 32'(8'h30 + i), 1, 0, 32'h0, $sformatf("flush push%0d", i));
    add(0, A_STATUS,  32'h0, 1, 0, 32'h0000_0500, "flush STATUS before");
    add(1, A_CONTROL, 32'h3, 1, 0, 32'h0,       "flush write");
    add(0, A_STATUS,  32'h0, 1, 0, 32'h0000_0002, "flush STATUS after");
    add(0, A_CONTROL, 32'h0, 1, 0, 32'h1,       "flush CONTROL");
    run_table();
    for (int i = 0; i < 10; i++) begin
      check("flush nothing sent", char_valid_o, 1'b0);
      tick();
    end

    // ---------------- flow control ----------------
    do_reset();
    cts_i = 1'b0;
    for (int i = 0; i < 4; i++) add(1, A_DATA, 32'(fc_bytes[i]), 1, 0, 32'h0, $sformatf("fc push%0d", i));
    run_table();
    for (int i = 0; i < 12; i++) begin
      check("fc held tx", tx_o, 1'b1);
      check("fc held strobe", char_valid_o, 1'b0);
      tick();
    end
    add(0, A_STATUS, 32'h0, 1, 0, 32'h0000_0400, "fc STATUS held");
    run_table();
    cts_i = 1'b1;
    for (int i = 1; i <= 3 * (FRAME + 1) + 20; i++) begin
      logic exp_tx;
      logic exp_cv;
      tick();
      exp_tx = 1'b1;
      exp_cv = 1'b0;
      for (int k = 0; k < 3; k++) begin
        p = 1 + k * (FRAME + 1);
        if (i == p) begin
          exp_cv = 1'b1;
          check($sformatf("fc char_o%0d", k), char_o, fc_bytes[k]);
        end
        if (i - p >= 0 && i - p < FRAME) exp_tx = uart_level(i - p, fc_bytes[k]);
      end
      check($sformatf("fc strobe@%0d", i), char_valid_o, exp_cv);
      check($sformatf("fc tx@%0d", i), tx_o, exp_tx);
      if (i == 1 + 2 * (FRAME + 1) + 15) cts_i = 1'b0;
    end
    add(0, A_STATUS, 32'h0, 1, 0, 32'h0000_0100, "fc STATUS after drop");
    run_table();

    // ---------------- reset mid-frame ----------------
    do_reset();
    add(1, A_DATA, 32'h5A, 1, 0, 32'h0, "rst push0");
    add(1, A_DATA, 32'h33, 1, 0, 32'h0, "rst push1");
    add(1, A_DATA, 32'h44, 1, 0, 32'h0, "rst push2");
    run_table();
    for (int i = 0; i < 8; i++) tick();
    check("rst in data bit", tx_o, uart_level(9, 8'h5A));
    rst_n_i = 1'b0;
    tick();
    check("rst tx high", tx_o, 1'b1);
    check("rst strobe low", char_valid_o, 1'b0);
    check("rst write_done low", write_done_o, 1'b0);
    rst_n_i = 1'b1;
    add(0, A_STATUS, 32'h0, 1, 0, 32'h0000_0002, "rst STATUS empty");
    run_table();
    for (int i = 0; i < 60; i++) begin
      check("rst no strobe", char_valid_o, 1'b0);
      check("rst tx idle", tx_o, 1'b1);
      tick();
    end

    // ---------------- model-checked runs ----------------
    run_model(1800, 1'b1);
    run_model(2000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
